// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the E-stage multiply/divide unit.
//   - MD_* operation codes carried from decode into the E stage
//   - mdu_state_t: IDLE/RUN state encoding of the MDU core
//   - DEF_MULT_CYCLES / DEF_DIV_CYCLES: default busy durations
//   - md_decode(): instruction -> {op, start}. Both the hazard unit
//     (D stage) and the E stage call it, so they always agree on which
//     instructions are MD-class.
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic       start;
    } md_dec_t;

    // MIPS R-type (opcode 0) funct field selects the HI/LO instructions.
    // start is asserted only for the four instructions that launch a
    // multi-cycle operation; mfhi/mflo/mthi/mtlo are single-cycle.
    function automatic md_dec_t md_decode(input logic [31:0] instr);
        md_dec_t d;
        d.op    = MD_NONE;
        d.start = 1'b0;
        if (instr[31:26] == 6'd0) begin
            case (instr[5:0])
                6'h18:   d.op = MD_MULT;
                6'h19:   d.op = MD_MULTU;
                6'h1a:   d.op = MD_DIV;
                6'h1b:   d.op = MD_DIVU;
                6'h10:   d.op = MD_MFHI;
                6'h12:   d.op = MD_MFLO;
                6'h11:   d.op = MD_MTHI;
                6'h13:   d.op = MD_MTLO;
                default: d.op = MD_NONE;
            endcase
        end
        d.start = (d.op >= MD_MULT) && (d.op <= MD_DIVU);
        return d;
    endfunction

endpackage

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit holding architectural HI/LO.
// The full 64-bit result is computed combinationally at the start edge
// and parked in pend_hi/pend_lo; busy then models the latency of the
// unit, and HI/LO are committed on the last busy edge.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   E-stage instruction is mult/multu/div/divu
//   op       in   MD_* operation code (mdu_pkg)
//   A, B     in   forwarded rs / rt operands
//   busy     out  high while an operation is in flight (registered)
//   hi, lo   out  current HI / LO registers
//   rd_data  out  hi when op==MD_MFHI, else lo (combinational)
module mdu_e
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      pend_hi_reg;
    logic [31:0]      pend_lo_reg;

    logic             is_md_op;
    logic             is_mul_op;
    logic             is_signed_div;
    logic [31:0]      div_n;
    logic [31:0]      div_d;
    logic [31:0]      div_q;
    logic [31:0]      div_r;
    logic [63:0]      prod;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    assign is_md_op      = (op >= MD_MULT) && (op <= MD_DIVU);
    assign is_mul_op     = (op == MD_MULT) || (op == MD_MULTU);
    assign is_signed_div = (op == MD_DIV);

    // Signed divide runs on magnitudes and fixes signs afterwards. This
    // keeps a single unsigned divider and makes 0x80000000 / -1 fall out
    // naturally: |A|=0x80000000, |B|=1, same signs -> q=0x80000000, r=0.
    assign div_n = (is_signed_div && A[31]) ? (32'd0 - A) : A;
    assign div_d = (is_signed_div && B[31]) ? (32'd0 - B) : B;
    assign div_q = div_n / div_d;
    assign div_r = div_n % div_d;

    // A 64x64 product of sign-extended operands, truncated to 64 bits,
    // equals the signed 32x32 product; zero-extension gives the unsigned one.
    always_comb begin
        prod = 64'd0;
        if (op == MD_MULT) begin
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end else if (op == MD_MULTU) begin
            prod = {32'd0, A} * {32'd0, B};
        end
    end

    always_comb begin
        res_hi = hi_reg;
        res_lo = lo_reg;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_DIV: begin
                // Divide by zero keeps the current HI/LO.
                if (B != 32'd0) begin
                    res_lo = (A[31] ^ B[31]) ? (32'd0 - div_q) : div_q;
                    res_hi = A[31] ? (32'd0 - div_r) : div_r;
                end
            end
            MD_DIVU: begin
                if (B != 32'd0) begin
                    res_lo = div_q;
                    res_hi = div_r;
                end
            end
            default: begin
                res_hi = hi_reg;
                res_lo = lo_reg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && is_md_op) begin
                        pend_hi_reg <= res_hi;
                        pend_lo_reg <= res_lo;
                        cnt_reg     <= is_mul_op ? MULT_LOAD : DIV_LOAD;
                        state_reg   <= ST_RUN;
                        busy_reg    <= 1'b1;
                    end else if (op == MD_MTHI) begin
                        hi_reg <= A;
                    end else if (op == MD_MTLO) begin
                        lo_reg <= A;
                    end
                end
                ST_RUN: begin
                    // Inputs are ignored here; the hazard unit keeps new
                    // MD-class instructions out of E while busy.
                    if (cnt_reg == CNT_ONE) begin
                        hi_reg    <= pend_hi_reg;
                        lo_reg    <= pend_lo_reg;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign rd_data = (op == MD_MFHI) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e: directed test of mdu_e. A behavioural model tracks HI/LO,
// the pending result and the remaining busy cycles using plain 64-bit
// arithmetic; a compare process checks busy/hi/lo/rd_data against it on
// every falling edge, and directed literal checks pin the model.
module tb_mdu_e;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            ua = {32'd0, A};
            ub = {32'd0, B};
            if (start && op == MD_MULT) begin
                sq = sa * sb;
                m_phi = sq[63:32]; m_plo = sq[31:0]; m_left = MC;
            end else if (start && op == MD_MULTU) begin
                up = ua * ub;
                m_phi = up[63:32]; m_plo = up[31:0]; m_left = MC;
            end else if (start && op == MD_DIV) begin
                if (B == 0) begin m_phi = m_hi; m_plo = m_lo; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    m_plo = sq[31:0]; m_phi = sr[31:0];
                end
                m_left = DC;
            end else if (start && op == MD_DIVU) begin
                if (B == 0) begin m_phi = m_hi; m_plo = m_lo; end
                else begin
                    up = ua / ub; m_plo = up[31:0];
                    up = ua % ub; m_phi = up[31:0];
                end
                m_left = DC;
            end else if (op == MD_MTHI) begin
                m_hi = A;
            end else if (op == MD_MTLO) begin
                m_lo = A;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
            check("cyc_rd_data", rd_data, (op == MD_MFHI) ? m_hi : m_lo);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one op for exactly one clock edge; inputs change 2ns after posedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        start = (o >= MD_MULT) && (o <= MD_DIVU);
        op = o; A = a; B = b;
        @(posedge clk); #2;
        start = 1'b0; op = MD_NONE;
    endtask

    // Count busy cycles (sampled on falling edges) until busy drops.
    task automatic wait_busy(input string name, input int exp_cycles);
        int n;
        bit done;
        n = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1;
        end
        if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
        check({name, "_busy_cycles"}, n, exp_cycles);
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        issue(o, a, b);
        wait_busy(name, cyc);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        $display("txn %s A=0x%08h B=0x%08h -> hi=0x%08h lo=0x%08h", name, a, b, hi, lo);
    endtask

    initial begin
        int n;
        bit done;
        reset = 1'b0; start = 1'b0; op = MD_NONE; A = 0; B = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(posedge clk); #2; reset = 1'b1;

        run_op("mult",  MD_MULT,  32'hFFFFFFFF, 32'd2, MC, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, MC, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  MD_DIVU,  32'd7,        32'd2, DC, 32'd1,        32'd3);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, DC, 32'd0, 32'h80000000);

        // Divide by zero leaves preloaded HI/LO untouched.
        issue(MD_MTHI, 32'h11, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        run_op("div0", MD_DIV, 32'd5, 32'd0, DC, 32'h11, 32'h22);
        run_op("divu0", MD_DIVU, 32'd9, 32'd0, DC, 32'h11, 32'h22);

        // MTHI then MFHI/MFLO read-back.
        issue(MD_MTHI, 32'h12345678, 32'd0);
        #1;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = MD_MFHI; #1;
        check("mfhi_rd", rd_data, 32'h12345678);
        op = MD_MFLO; #1;
        check("mflo_rd", rd_data, 32'h22);
        $display("txn mthi/mfhi rd_data=0x%08h", rd_data);
        op = MD_NONE;

        // Reset in busy cycle 4 of a DIV: outputs clear without a clock edge.
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        #1; reset = 1'b0; #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        $display("txn reset mid-div busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
        @(posedge clk); #2; reset = 1'b1;
        issue(MD_MTLO, 32'h5, 32'd0);
        #1;
        check("post_rst_mtlo", lo, 32'h5);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        $display("txn mtlo after reset lo=0x%08h", lo);

        // start/MTLO arriving while busy are ignored.
        issue(MD_MULT, 32'd3, 32'hFFFFFFFC);
        n = 0; done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1;
            #1;
            if (k == 2) begin start = 1'b1; op = MD_DIV; A = 32'd9; B = 32'd2; end
            else if (k == 3) begin start = 1'b0; op = MD_MTLO; A = 32'hDEAD; end
            else if (k == 4) begin op = MD_NONE; end
        end
        if (!done) check("busy_ign_timeout", 32'd1, 32'd0);
        check("busy_ign_cycles", n, MC);
        check("busy_ign_hi", hi, 32'hFFFFFFFF);
        check("busy_ign_lo", lo, 32'hFFFFFFF4);
        $display("txn mult with ignored start -> hi=0x%08h lo=0x%08h", hi, lo);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
